// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32 definitions for the writeback-stage performance monitor.
//   - major opcode constants (instr[6:0])
//   - instr_class_t: the opcode classes the monitor counts separately
//   - decode_class(): combinational opcode -> class mapping
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int NUM_CLASSES = 8;

  typedef enum logic [2:0] {
    CLS_LOAD   = 3'd0,
    CLS_STORE  = 3'd1,
    CLS_BRANCH = 3'd2,
    CLS_JUMP   = 3'd3,
    CLS_ALU    = 3'd4,
    CLS_UPPER  = 3'd5,
    CLS_SYSTEM = 3'd6,
    CLS_OTHER  = 3'd7
  } instr_class_t;

  // Anything not recognised (including reserved/custom opcodes) lands in
  // CLS_OTHER so that every retired instruction is counted in exactly one class.
  function automatic instr_class_t decode_class(input logic [6:0] opcode);
    instr_class_t cls;
    cls = CLS_OTHER;
    case (opcode)
      OP_LOAD:           cls = CLS_LOAD;
      OP_STORE:          cls = CLS_STORE;
      OP_BRANCH:         cls = CLS_BRANCH;
      OP_JAL, OP_JALR:   cls = CLS_JUMP;
      OP_IMM, OP_REG:    cls = CLS_ALU;
      OP_LUI, OP_AUIPC:  cls = CLS_UPPER;
      OP_SYSTEM:         cls = CLS_SYSTEM;
      default:           cls = CLS_OTHER;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/retire_cycle_monitor_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with asynchronous active-low clear.
// Ports:
//   clk_i    in   clock
//   reset_i  in   asynchronous active-low clear
//   inc_i    in   increment request, sampled on the rising edge
//   count_o  out  WIDTH-bit registered count, sticks at all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  // An unknown inc_i makes the if-condition false in simulation, so the
  // count holds rather than going to X.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_count <= '0;
    end else if (inc_i && (r_count != MAX_VAL)) begin
      r_count <= r_count + ONE;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/retire_cycle_monitor.sv
// -----------------------------------------------------------------------------
// retire_cycle_monitor
// Passive performance monitor on the writeback stage. Every cycle out of reset
// is exactly one of: retire (valid & !stall), stall (stall), bubble
// (!valid & !stall). Retires are further split by opcode class. All counters
// saturate independently and clear asynchronously on reset.
// Ports:
//   clk_i          in   core clock
//   reset_i        in   asynchronous active-low reset
//   valid_w_i      in   writeback holds a real instruction
//   stall_w_i      in   writeback stalled this cycle
//   instr_w_i      in   instruction word in writeback (only [6:0] used)
//   cycle_cnt_o    out  cycles since reset release
//   retired_cnt_o  out  retired instructions
//   stall_cnt_o    out  stall cycles
//   bubble_cnt_o   out  bubble cycles
//   *_cnt_o        out  retired instructions per opcode class
// -----------------------------------------------------------------------------
module retire_cycle_monitor
  import riscv_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_w_i,
  input  logic             stall_w_i,
  input  logic [31:0]      instr_w_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retired_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] load_cnt_o,
  output logic [CNT_W-1:0] store_cnt_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] jump_cnt_o,
  output logic [CNT_W-1:0] alu_cnt_o,
  output logic [CNT_W-1:0] upper_cnt_o,
  output logic [CNT_W-1:0] system_cnt_o,
  output logic [CNT_W-1:0] other_cnt_o
);

  logic             w_retire;
  logic             w_stall;
  logic             w_bubble;
  instr_class_t     w_class;
  logic [NUM_CLASSES-1:0] w_class_inc;
  logic [CNT_W-1:0] w_class_cnt [NUM_CLASSES];

  // Kept under this name so benches can probe the cycle count hierarchically.
  logic [CNT_W-1:0] cycle_cnt;

  // Only the major opcode matters for classification.
  logic w_unused;
  assign w_unused = ^instr_w_i[31:7];

  // Stall dominates valid: a stalled valid instruction has not retired yet.
  assign w_stall  = stall_w_i;
  assign w_retire = valid_w_i & ~stall_w_i;
  assign w_bubble = ~valid_w_i & ~stall_w_i;
  assign w_class  = decode_class(instr_w_i[6:0]);

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (1'b1),
    .count_o (cycle_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_retired_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (w_retire),
    .count_o (retired_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (w_stall),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (w_bubble),
    .count_o (bubble_cnt_o)
  );

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_class
    assign w_class_inc[g] = w_retire && (w_class == instr_class_t'(g));

    sat_counter #(.WIDTH(CNT_W)) u_class_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .inc_i   (w_class_inc[g]),
      .count_o (w_class_cnt[g])
    );
  end

  assign cycle_cnt_o  = cycle_cnt;
  assign load_cnt_o   = w_class_cnt[CLS_LOAD];
  assign store_cnt_o  = w_class_cnt[CLS_STORE];
  assign branch_cnt_o = w_class_cnt[CLS_BRANCH];
  assign jump_cnt_o   = w_class_cnt[CLS_JUMP];
  assign alu_cnt_o    = w_class_cnt[CLS_ALU];
  assign upper_cnt_o  = w_class_cnt[CLS_UPPER];
  assign system_cnt_o = w_class_cnt[CLS_SYSTEM];
  assign other_cnt_o  = w_class_cnt[CLS_OTHER];

  // Simulation-only: unknown handshake bits would silently suppress counting.
  a_ctrl_known: assert property (
    @(posedge clk_i) disable iff (!reset_i) !$isunknown({valid_w_i, stall_w_i})
  ) else $error("retire_cycle_monitor: X/Z on valid_w_i/stall_w_i");

endmodule

// File: tb/tb_retire_cycle_monitor.sv
// -----------------------------------------------------------------------------
// tb_retire_cycle_monitor
// Drives a 64-bit and a 4-bit instance from the same stimulus. A counting
// model (plain integers, no saturation) tracks what every counter must be;
// the 4-bit instance is expected to read min(model, 15).
// -----------------------------------------------------------------------------
module tb_retire_cycle_monitor;

  localparam int NC = 12;
  localparam int NW = 4;
  localparam logic [63:0] NARROW_MAX = 64'd15;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instr = '0;

  // index: 0 cycle, 1 retired, 2 stall, 3 bubble,
  //        4 load, 5 store, 6 branch, 7 jump, 8 alu, 9 upper, 10 system, 11 other
  logic [63:0]   w_cnt [NC];
  logic [NW-1:0] n_cnt [NC];

  int n_vec = 0;
  int n_err = 0;

  longint unsigned m [NC] = '{default: 0};

  string names [NC] = '{"cycle", "retired", "stall", "bubble", "load", "store",
                        "branch", "jump", "alu", "upper", "system", "other"};

  logic [6:0] ops [10] = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                           7'h13, 7'h33, 7'h37, 7'h17, 7'h73};

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  retire_cycle_monitor dut (
    .clk_i(clk), .reset_i(rst_n), .valid_w_i(valid), .stall_w_i(stall), .instr_w_i(instr),
    .cycle_cnt_o(w_cnt[0]), .retired_cnt_o(w_cnt[1]), .stall_cnt_o(w_cnt[2]),
    .bubble_cnt_o(w_cnt[3]), .load_cnt_o(w_cnt[4]), .store_cnt_o(w_cnt[5]),
    .branch_cnt_o(w_cnt[6]), .jump_cnt_o(w_cnt[7]), .alu_cnt_o(w_cnt[8]),
    .upper_cnt_o(w_cnt[9]), .system_cnt_o(w_cnt[10]), .other_cnt_o(w_cnt[11])
  );

  retire_cycle_monitor #(.CNT_W(NW)) dut_n (
    .clk_i(clk), .reset_i(rst_n), .valid_w_i(valid), .stall_w_i(stall), .instr_w_i(instr),
    .cycle_cnt_o(n_cnt[0]), .retired_cnt_o(n_cnt[1]), .stall_cnt_o(n_cnt[2]),
    .bubble_cnt_o(n_cnt[3]), .load_cnt_o(n_cnt[4]), .store_cnt_o(n_cnt[5]),
    .branch_cnt_o(n_cnt[6]), .jump_cnt_o(n_cnt[7]), .alu_cnt_o(n_cnt[8]),
    .upper_cnt_o(n_cnt[9]), .system_cnt_o(n_cnt[10]), .other_cnt_o(n_cnt[11])
  );

  // ---------------------------------------------------------------- model
  function automatic int class_idx(input logic [31:0] ins);
    case (ins[6:0])
      7'h03:        return 4;
      7'h23:        return 5;
      7'h63:        return 6;
      7'h6F, 7'h67: return 7;
      7'h13, 7'h33: return 8;
      7'h37, 7'h17: return 9;
      7'h73:        return 10;
      default:      return 11;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) m[i] <= 0;
    end else begin
      m[0] <= m[0] + 1;
      if (stall) begin
        m[2] <= m[2] + 1;
      end else if (valid) begin
        m[1] <= m[1] + 1;
        m[class_idx(instr)] <= m[class_idx(instr)] + 1;
      end else begin
        m[3] <= m[3] + 1;
      end
    end
  end

  function automatic logic [63:0] sat_n(input longint unsigned v);
    return (v > NARROW_MAX) ? NARROW_MAX : v;
  endfunction

  // ---------------------------------------------------------------- scoreboard
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < NC; i++) begin
      chk({tag, "_w_", names[i]}, w_cnt[i], 64'd0);
      chk({tag, "_n_", names[i]}, {{(64-NW){1'b0}}, n_cnt[i]}, 64'd0);
    end
  endtask

  // Compare on the falling edge, away from the update edge.
  always @(negedge clk) begin
    logic [63:0] cls_sum;
    cls_sum = '0;
    for (int i = 0; i < NC; i++) begin
      chk({"w_", names[i]}, w_cnt[i], m[i]);
      chk({"n_", names[i]}, {{(64-NW){1'b0}}, n_cnt[i]}, sat_n(m[i]));
    end
    for (int i = 4; i < NC; i++) cls_sum = cls_sum + w_cnt[i];
    chk("inv_cycle_sum", w_cnt[0], w_cnt[1] + w_cnt[2] + w_cnt[3]);
    chk("inv_class_sum", cls_sum, w_cnt[1]);
    chk("probe_cycle_cnt", dut.cycle_cnt, w_cnt[0]);
  end

  // ---------------------------------------------------------------- driver
  // Inputs change 2 time units after a rising edge and are sampled on the next.
  task automatic drive(input logic v, input logic s, input logic [31:0] ins);
    valid = v;
    stall = s;
    instr = ins;
    @(posedge clk);
    #2;
  endtask

  task automatic drive_random();
    logic [31:0] ins;
    ins = $urandom();
    if ($urandom_range(0, 3) != 0) ins[6:0] = ops[$urandom_range(0, 9)];
    drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ins);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [31:0] prog [8] = '{32'h00002083, 32'h00102023, 32'h00000063, 32'h0000006F,
                            32'h00100093, 32'h000010B7, 32'h00000073, 32'h0000007F};

  initial begin
    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    #1;
    rst_n = 1'b1;

    // Idle: 10 bubble cycles.
    repeat (10) drive(1'b0, 1'b0, 32'h0);
    chk("t1_cycle", w_cnt[0], 64'd10);
    chk("t1_bubble", w_cnt[3], 64'd10);
    chk("t1_retired", w_cnt[1], 64'd0);
    chk("t1_model_cycle", m[0], 64'd10);
    chk("t1_n_cycle", {60'd0, n_cnt[0]}, 64'd10);

    // One retire per class.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, prog[i]);
    chk("t2_retired", w_cnt[1], 64'd8);
    for (int i = 4; i < NC; i++) chk({"t2_", names[i]}, w_cnt[i], 64'd1);
    chk("t2_cycle", w_cnt[0], 64'd18);
    chk("t2_n_cycle_sat", {60'd0, n_cnt[0]}, 64'd15);

    // Valid but stalled: only the stall counter moves.
    repeat (5) drive(1'b1, 1'b1, 32'h00100093);
    chk("t3_stall", w_cnt[2], 64'd5);
    chk("t3_retired", w_cnt[1], 64'd8);
    chk("t3_alu", w_cnt[8], 64'd1);

    // Random mix.
    repeat (1000) drive_random();

    // Asynchronous reset in the middle of a cycle after 50 more cycles.
    repeat (50) drive_random();
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_probe", dut.cycle_cnt, 64'd0);
    @(posedge clk);
    #2;
    chk_all_zero("held_rst");
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    chk("t5_cycle_restart", w_cnt[0], 64'd1);
    chk("t5_bubble_restart", w_cnt[3], 64'd1);
    chk("t5_n_cycle_restart", {60'd0, n_cnt[0]}, 64'd1);

    // Narrow instance must pin at 15.
    repeat (20) drive_random();
    chk("t6_n_cycle_hold", {60'd0, n_cnt[0]}, 64'd15);
    chk("t6_w_cycle", w_cnt[0], 64'd21);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/retire_cycle_monitor.md
Name: retire_cycle_monitor

Overview:
Non-intrusive performance monitor attached to the writeback stage of the pipelined RISC-V core. It counts:
- elapsed clock cycles
- retired instructions
- writeback stall cycles
- bubble cycles
- retired instructions per opcode class

Counters are readable as outputs for benches and debug. It does not feed back into the core.

Parameters:
- CNT_W, 64, width of every counter.

Ports:
- clk_i  input  1  core clock
- reset_i  input  1  asynchronous, active-low reset
- valid_w_i  input  1  writeback stage holds a real instruction
- stall_w_i  input  1  writeback stage stalled this cycle
- instr_w_i  input  32  instruction word in writeback
- cycle_cnt_o  output  CNT_W  cycles since reset release
- retired_cnt_o  output  CNT_W  retired instructions
- stall_cnt_o  output  CNT_W  cycles with stall_w_i=1
- bubble_cnt_o  output  CNT_W  cycles with valid_w_i=0 and stall_w_i=0
- load_cnt_o, store_cnt_o, branch_cnt_o, jump_cnt_o, alu_cnt_o, upper_cnt_o, system_cnt_o, other_cnt_o  output  CNT_W each  retired instructions per class

Behaviour:
- Reset: asynchronous and active-low. While reset_i=0, every counter output is 0.
- cycle_cnt_o:
  - Increments by 1 on every rising clk_i edge while reset_i=1.
  - The first post-reset edge makes it 1.
  - The internal register is named cycle_cnt so benches can probe it hierarchically.
- Per-cycle classification: each cycle falls into exactly one of three categories.
  - Retire: valid_w_i=1 and stall_w_i=0. Increments retired_cnt_o plus exactly one class counter.
  - Stall: stall_w_i=1, regardless of valid_w_i. Increments stall_cnt_o only.
  - Bubble: valid_w_i=0 and stall_w_i=0. Increments bubble_cnt_o only.
- Invariant, every cycle: cycle_cnt = retired + stall + bubble.
- Class decode uses instr_w_i[6:0], and only on retire:
  - 0000011 -> load
  - 0100011 -> store
  - 1100011 -> branch
  - 1101111 and 1100111 (jal, jalr) -> jump
  - 0010011 and 0110011 -> alu
  - 0110111 and 0010111 (lui, auipc) -> upper
  - 1110011 -> system
  - any other opcode -> other
- Invariant: the sum of the class counters equals retired_cnt_o.
- Latency: all counters update on the same edge that samples the inputs. Outputs are registered, so there is one cycle from input to visible count.
- Saturation: every counter saturates at 2^CNT_W-1 and never wraps.
  - cycle_cnt saturating does not stop the other counters; each saturates independently.
- Reset mid-run: counts clear immediately (asynchronously). They resume from 0 on the first edge after release.
- X/Z on valid_w_i or stall_w_i: counters must not increment. Add a simulation-only assertion that flags it.
- Purely observational: no outputs drive the core.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_IMM, OP_REG, OP_LUI, OP_AUIPC, OP_SYSTEM)
  - an enum instr_class_t {CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_ALU, CLS_UPPER, CLS_SYSTEM, CLS_OTHER}
- One sub-module, sat_counter:
  - Parameter: width.
  - Ports: clk_i, reset_i, inc_i, count_o.
  - Saturating increment with asynchronous active-low clear.
  - Instantiated 12 times.
- Opcode-to-class decode is a combinational function in the package.

Test Plan:
1. Hold reset_i=0 for 2 cycles, then release. After 10 edges, cycle_cnt_o=10 and all other counters are 0 (valid_w_i=0, stall_w_i=0), so bubble_cnt_o=10.
2. Retire, one per cycle, lw (0x00002083), sw (0x00102023), beq (0x00000063), jal (0x0000006F), addi (0x00100093), lui (0x000010B7), ecall (0x00000073), opcode 0x7F. Result: each class counter = 1 (jump=1, alu=1, upper=1), retired_cnt_o=8.
3. Drive valid_w_i=1 and stall_w_i=1 for 5 cycles with addi. Result: stall_cnt_o increases by 5; retired_cnt_o and alu_cnt_o unchanged.
4. Run a random mix of valid/stall for 1000 cycles. Check every cycle that cycle = retired + stall + bubble, and that the class sum = retired.
5. Assert reset_i=0 asynchronously mid-cycle after 50 cycles. All outputs read 0 before the next edge; counting restarts at 1 after release.
6. Instantiate with CNT_W=4 and run 20 cycles. cycle_cnt_o holds at 15 and does not wrap; the other counters saturate independently.
